aes_encrypt_iter: RTL and testbench
===================================

// Module: aes_encrypt_iter
// PURPOSE
//  Iterative, key-agile AES encryptor: one round per clock, AES-128/192/256 chosen per key load.
//  On-chip key schedule is computed once per key and stored; many blocks then encrypt under it.
//  Replaces the fully unrolled combinational encryptor where area matters. Sits between the
//  sender's key store and the ciphertext framing logic, with valid/ready on all three channels.
// PARAMETERS
//  MAX_NK    8    max key words supported (4, 6 or 8); key_len above MAX_NK sets key_err
//  N         128  block width, fixed at 128
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    asynchronous active-low reset
//  key_valid  in   1    key channel valid
//  key_ready  out  1    key channel ready
//  key_len    in   2    0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//  key        in   256  key, MSB-aligned: w0=key[255:224]; 128-bit uses [255:128], 192-bit uses [255:64]
//  in_valid   in   1    plaintext valid
//  in_ready   out  1    plaintext ready
//  in_data    in   128  plaintext, byte0 = in_data[127:120]
//  out_valid  out  1    ciphertext valid
//  out_ready  in   1    ciphertext ready
//  out_data   out  128  ciphertext
//  busy       out  1    high in KEXP or ROUND
//  key_err    out  1    one-cycle pulse on rejected key
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
//  Reset: FSM=IDLE, key invalid. key_ready=1. in_ready=0, out_valid=0, busy=0, key_err=0, out_data=0.
//  Nk = 4/6/8 and Nr = Nk+6 (10/12/14), both latched on key accept.
//  FSM states: IDLE (no key), KEXP, READY, ROUND, DONE.
//  Key handshake: key_ready=1 only in IDLE and READY. A transfer occurs when key_valid&key_ready.
//   Legal key_len: load w[0..Nk-1] from key, go to KEXP. Any key held in READY is discarded.
//   Illegal key (len 3, or Nk>MAX_NK): key_err=1 for 1 cycle, nothing stored, state unchanged.
//  KEXP:
//   Computes one word per cycle, w[i] for i=Nk..4*(Nr+1)-1, per FIPS-197 (RotWord/SubWord/Rcon).
//   The extra SubWord step applies when Nk=8 and i mod 8 = 4.
//   Takes 40/46/52 cycles for 128/192/256, then goes to READY. Stored as 15x128 round-key regs.
//  Input handshake: in_ready=1 only in READY.
//   On in_valid&in_ready at edge E: state <= in_data ^ rk[0], round counter r <= 1, go to ROUND.
//  ROUND: each edge applies SubBytes, ShiftRows, MixColumns, AddRoundKey(rk[r]), then r++.
//   When r==Nr, MixColumns is skipped, the result goes to out_data and the FSM enters DONE.
//  Latency: out_valid rises Nr edges after E (10/12/14). out_data is registered.
//  DONE: out_valid=1, out_data stable until out_valid&out_ready; then out_valid=0, go to READY.
//   in_ready stays 0 in DONE: one block in flight. Max throughput is 1 block per Nr+2 cycles.
//  Simultaneous events:
//   key_valid is ignored in KEXP/ROUND/DONE (key_ready=0).
//   In READY, if key_valid and in_valid are both high, the key wins: in_ready is forced 0 that cycle.
//  rst_n assertion mid-KEXP/ROUND/DONE: aborts immediately, pending output lost, key must be reloaded.
//  Round counter is 4 bits. The round-key index never exceeds Nr. No wrap is possible.
// TESTING
//  FIPS-197 C.1: key_len=0, key=000102..0f<<128, pt=00112233445566778899aabbccddeeff
//   -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
//  FIPS-197 C.2: key_len=1, key=000102..17<<64, same pt
//   -> ct dda97ca4864cdfe06eaf70a0ec0d7191, KEXP 46 cycles, latency 12.
//  FIPS-197 C.3: key_len=2, key=000102..1f, same pt
//   -> ct 8ea2b7ca516745bfeafc49904b496089, latency 14.
//  Key reuse and backpressure: C.3 key, 3 blocks back-to-back, out_ready held 0 for 5 cycles
//   -> out_data stable, in_ready=0 throughout, all 3 cts correct in order.
//  Illegal key: READY under C.1 key, key_len=3 -> key_err one-cycle pulse, state stays READY,
//   next block still yields 69c4e0d8...
//  Reset mid-ROUND: rst_n low at round 5 -> out_valid=0, in_ready=0, key_ready=1;
//   after reload the C.1 vector passes.

Source files
------------

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock, key schedule stored on chip.
// Latency: key expansion 40/46/52 cycles per key; a block takes Nr (10/12/14) edges from accept to out_valid.
// Backpressure: one block in flight; the result is held in DONE until out_ready, and in_ready stays low until then.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   key_valid/key_ready/key_len/key  key channel (key MSB-aligned, w0 = key[255:224])
//   in_valid/in_ready/in_data        plaintext channel (byte0 = in_data[127:120])
//   out_valid/out_ready/out_data     ciphertext channel (registered data)
//   busy                             high while expanding a key or running rounds
//   key_err                          one-cycle pulse after a rejected key
module aes_encrypt_iter #(
  parameter int MAX_NK = 8,
  parameter int N      = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         key_err
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_READY, S_ROUND, S_DONE} state_e;

  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  state_e       st_q, st_d;
  logic [3:0]   nk_q, nk_d, nr_q, nr_d, rnd_q, rnd_d;
  logic [5:0]   wi_q, wi_d;       // index of the schedule word being produced
  logic [2:0]   km_q, km_d;       // wi mod Nk, kept as a wrapping counter
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  win_q [8];        // last Nk schedule words, win_q[0] newest
  logic [31:0]  win_d [8];
  logic [127:0] rk_q [15];
  logic [127:0] rk_d [15];
  logic [127:0] blk_q, blk_d, out_q, out_d;
  logic         key_err_q, key_err_d;

  // ---------------- GF(2^8) helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0]  x;
    logic [7:0]  r;
    logic [15:0] bb;
    x = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    bb = {r, r};
    return r ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
  endfunction

  // ---------------- key intake ----------------
  logic [3:0]  nk_in;
  logic        key_legal;
  logic [31:0] key_w [8];

  assign nk_in     = 4'd4 + {1'b0, key_len, 1'b0};
  assign key_legal = (key_len != 2'd3) && (nk_in <= MAX_NK_L);

  always_comb begin
    for (int j = 0; j < 8; j++) key_w[j] = key[255-32*j -: 32];
  end

  // ---------------- key expansion word ----------------
  logic [31:0] w_prev, w_back, sw_in, sw_out, w_new;

  always_comb begin
    w_prev = win_q[0];
    w_back = win_q[3'(nk_q - 4'd1)];
    sw_in  = (km_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sw_out = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
    if (km_q == 3'd0)
      w_new = w_back ^ sw_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && km_q == 3'd4)
      w_new = w_back ^ sw_out;
    else
      w_new = w_back ^ w_prev;
  end

  // ---------------- round datapath ----------------
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] rnd_res;
  logic         last_rnd;

  assign last_rnd = (rnd_q == nr_q);

  always_comb begin
    rnd_res = '0;
    for (int b = 0; b < 16; b++) sb[b] = sbox(blk_q[127-8*b -: 8]);
    // byte index = row + 4*col; row r rotates left by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r+4*c] = sb[r + 4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int b = 0; b < 16; b++) rnd_res[127-8*b -: 8] = last_rnd ? sr[b] : mc[b];
    rnd_res = rnd_res ^ rk_q[rnd_q];
  end

  // ---------------- control ----------------
  assign key_ready = (st_q == S_IDLE) || (st_q == S_READY);
  assign in_ready  = (st_q == S_READY) && !key_valid;   // a pending key takes priority
  assign out_valid = (st_q == S_DONE);
  assign busy      = (st_q == S_KEXP) || (st_q == S_ROUND);
  assign out_data  = out_q;
  assign key_err   = key_err_q;

  always_comb begin
    st_d      = st_q;
    nk_d      = nk_q;
    nr_d      = nr_q;
    rnd_d     = rnd_q;
    wi_d      = wi_q;
    km_d      = km_q;
    rcon_d    = rcon_q;
    win_d     = win_q;
    rk_d      = rk_q;
    blk_d     = blk_q;
    out_d     = out_q;
    key_err_d = 1'b0;
    case (st_q)
      S_IDLE, S_READY: begin
        if (key_valid) begin
          if (key_legal) begin
            nk_d   = nk_in;
            nr_d   = nk_in + 4'd6;
            wi_d   = {2'b00, nk_in};
            km_d   = 3'd0;
            rcon_d = 8'h01;
            // rk[1] lower words are overwritten by expansion when Nk < 8
            rk_d[0] = key[255:128];
            rk_d[1] = key[127:0];
            for (int k = 0; k < 8; k++)
              win_d[k] = (4'(k) < nk_in) ? key_w[3'(nk_in - 4'd1 - 4'(k))] : 32'h0;
            st_d = S_KEXP;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (st_q == S_READY && in_valid && in_ready) begin
          blk_d = in_data ^ rk_q[0];
          rnd_d = 4'd1;
          st_d  = S_ROUND;
        end
      end
      S_KEXP: begin
        rk_d[wi_q[5:2]][(7'd96 - {wi_q[1:0], 5'd0}) +: 32] = w_new;
        win_d[0] = w_new;
        for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
        wi_d = wi_q + 6'd1;
        km_d = (km_q == 3'(nk_q - 4'd1)) ? 3'd0 : km_q + 3'd1;
        if (km_q == 3'd0) rcon_d = xtime(rcon_q);
        if (wi_q == {nr_q, 2'b11}) st_d = S_READY;
      end
      S_ROUND: begin
        blk_d = rnd_res;
        rnd_d = rnd_q + 4'd1;
        if (last_rnd) begin
          out_d = rnd_res;
          st_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) st_d = S_READY;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      nk_q      <= 4'd4;
      nr_q      <= 4'd10;
      rnd_q     <= 4'd0;
      wi_q      <= 6'd0;
      km_q      <= 3'd0;
      rcon_q    <= 8'h01;
      blk_q     <= '0;
      out_q     <= '0;
      key_err_q <= 1'b0;
      for (int k = 0; k < 8; k++)  win_q[k] <= '0;
      for (int k = 0; k < 15; k++) rk_q[k]  <= '0;
    end else begin
      st_q      <= st_d;
      nk_q      <= nk_d;
      nr_q      <= nr_d;
      rnd_q     <= rnd_d;
      wi_q      <= wi_d;
      km_q      <= km_d;
      rcon_q    <= rcon_d;
      blk_q     <= blk_d;
      out_q     <= out_d;
      key_err_q <= key_err_d;
      win_q     <= win_d;
      rk_q      <= rk_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, backpressure, illegal key,
// key/plaintext collision, mid-round reset, and random keys/blocks against a byte-level AES model.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic         key_err;

  int tests = 0;
  int fails = 0;

  logic [2047:0] sbox_tbl;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.MAX_NK(8), .N(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_len(key_len), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .key_err(key_err)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] sbm(input logic [7:0] x);
    int xi;
    xi = int'(x);
    return sbox_tbl[2047 - 8*xi -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbm(w[31:24]), sbm(w[23:16]), sbm(w[15:8]), sbm(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_model(input logic [1:0] len, input logic [255:0] k,
                                              input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   rc;
    logic [127:0] res;
    int nk, nr;
    nk = 4 + 2*int'(len);
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int b = 0; b < 16; b++) u[b] = sbm(s[b]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = u[r + 4*((c+r)%4)];
      if (rnd < nr) begin
        for (int b = 0; b < 16; b++) u[b] = s[b];
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = xt(u[4*c]) ^ (xt(u[4*c+1]) ^ u[4*c+1]) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ xt(u[4*c+1]) ^ (xt(u[4*c+2]) ^ u[4*c+2]) ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ (xt(u[4*c+3]) ^ u[4*c+3]);
          s[4*c+3] = (xt(u[4*c]) ^ u[4*c]) ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
    end
    res = '0;
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: handshake/event did not occur within cycle budget", nm);
  endtask

  // Present a key, wait for acceptance, then measure expansion time (exp_kexp < 0 skips the check).
  task automatic send_key(input logic [1:0] len, input logic [255:0] k, input int exp_kexp,
                          input string nm);
    int n;
    bit ok;
    key_valid = 1'b1;
    key_len   = len;
    key       = k;
    n = 0;
    do begin
      @(negedge clk); ok = key_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    key_valid = 1'b0;
    if (!ok) begin timeout({nm, "_key_accept"}); return; end
    chk({nm, "_busy_kexp"}, busy, 1'b1);
    n = 0;
    while (!key_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!key_ready) begin timeout({nm, "_kexp_done"}); return; end
    if (exp_kexp >= 0) chk({nm, "_kexp_cycles"}, n, exp_kexp);
  endtask

  // Send one block, check latency, hold off out_ready for 'stall' cycles checking the held result.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] exp, input int exp_lat,
                            input int stall, input string nm);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_data  = pt;
    n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    if (!ok) begin timeout({nm, "_in_accept"}); return; end
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin timeout({nm, "_out_valid"}); return; end
    chk({nm, "_latency"}, n, exp_lat);
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_stall_data"}, out_data, exp);
      chk({nm, "_stall_in_ready"}, in_ready, 1'b0);
      chk({nm, "_stall_valid"}, out_valid, 1'b1);
      @(posedge clk); #1;
    end
    chk({nm, "_ct"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, out_valid, 1'b0);
  endtask

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           kexp;
    int           lat;
  } vec_t;

  vec_t vecs [3];

  logic [255:0] k1, k3, rk;
  logic [127:0] pt0, p, e;
  logic [1:0]   rl;
  int           errs;

  initial begin
    sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    pt0 = 128'h00112233445566778899aabbccddeeff;
    k1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    k3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    vecs[0] = '{2'd0, k1, pt0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 40, 10};
    vecs[1] = '{2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, pt0,
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 46, 12};
    vecs[2] = '{2'd2, k3, pt0, 128'h8ea2b7ca516745bfeafc49904b496089, 52, 14};

    // Reset values, checked while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1'b0);

    // FIPS-197 vectors
    for (int v = 0; v < 3; v++) begin
      send_key(vecs[v].len, vecs[v].key, vecs[v].kexp, $sformatf("fips%0d", v));
      send_block(vecs[v].pt, vecs[v].ct, vecs[v].lat, 0, $sformatf("fips%0d", v));
    end

    // Key reuse with output backpressure: three blocks under the AES-256 key
    for (int b = 0; b < 3; b++) begin
      p = (b == 0) ? pt0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      e = (b == 0) ? vecs[2].ct : aes_model(2'd2, k3, p);
      send_block(p, e, 14, 5, $sformatf("bp%0d", b));
    end

    // Illegal key while holding a valid AES-128 key
    send_key(2'd0, k1, 40, "reload_c1");
    key_valid = 1'b1;
    key_len   = 2'd3;
    key       = {8{$urandom()}};
    @(negedge clk);
    chk("illegal_key_ready", key_ready, 1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("illegal_stays_ready", key_ready, 1'b1);
    chk("illegal_not_busy", busy, 1'b0);
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      if (key_err) errs++;
      @(posedge clk); #1;
    end
    chk("key_err_pulse_cycles", errs, 1);
    send_block(pt0, vecs[0].ct, 10, 0, "after_illegal");

    // Key and plaintext offered together in READY: key wins
    key_valid = 1'b1;
    key_len   = 2'd0;
    key       = k1;
    in_valid  = 1'b1;
    in_data   = pt0;
    @(negedge clk);
    chk("collide_in_ready", in_ready, 1'b0);
    chk("collide_key_ready", key_ready, 1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    chk("collide_key_taken", busy, 1'b1);
    repeat (45) @(posedge clk);
    #1;
    chk("collide_no_block", out_valid, 1'b0);
    chk("collide_ready_again", in_ready, 1'b1);

    // Reset in the middle of the rounds
    in_valid = 1'b1;
    in_data  = pt0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready_low", in_ready, 1'b0);
    chk("midrst_key_ready", key_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_needs_key", in_ready, 1'b0);
    send_key(2'd0, k1, 40, "midrst_reload");
    send_block(pt0, vecs[0].ct, 10, 0, "midrst_c1");

    // Random keys of each length, random blocks and backpressure
    for (int t = 0; t < 6; t++) begin
      rl = 2'($urandom_range(0, 2));
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      send_key(rl, rk, 4*(int'(rl)*2 + 11) - (4 + 2*int'(rl)), $sformatf("rnd%0d", t));
      for (int b = 0; b < 4; b++) begin
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(p, aes_model(rl, rk, p), 10 + 2*int'(rl), int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d_%0d", t, b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
